// File: rtl/store_data_align.sv
// store_data_align: store-path write formatter for the memory stage.
// Truncates the register value to the store size, places it in the byte
// lanes selected by the address offset, and issues one or two word-aligned
// write beats over a valid/ready handshake.
// Optional feature macro: STORE_MISALIGNED_SPLIT_EN. When it is defined,
// stores that cross a word boundary are split into two beats. When it is
// undefined, such stores are rejected with err.
module store_data_align #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    input  logic [1:0]            req_size,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef STORE_MISALIGNED_SPLIT_EN
    localparam int LANE_W = 64;
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;
`else
    // Without splitting only the low word of the lane can ever be issued.
    localparam int LANE_W = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1} state_t;
`endif

    state_t state;

    // Request-side formatting, evaluated on the live request inputs.
    logic [1:0]        off;
    logic [31:0]       trunc;
    logic [3:0]        mask4;
    logic              size_ok;
    logic [LANE_W-1:0] lane;
    logic [7:0]        mask8;
    logic              crosses;
    logic              reject;
    logic              accept;

`ifdef STORE_MISALIGNED_SPLIT_EN
    // Second-beat payload, captured when the request is accepted.
    logic              need_hi;
    logic [31:0]       hi_wdata;
    logic [3:0]        hi_be;
`endif

    // Size decode: truncate the data and pick the unshifted byte mask.
    always_comb begin
        trunc   = 32'h0;
        mask4   = 4'b0000;
        size_ok = 1'b1;
        case (req_size)
            SZ_BYTE: begin
                trunc = {24'h0, req_data[7:0]};
                mask4 = 4'b0001;
            end
            SZ_HALF: begin
                trunc = {16'h0, req_data[15:0]};
                mask4 = 4'b0011;
            end
            SZ_WORD: begin
                trunc = req_data;
                mask4 = 4'b1111;
            end
            default: begin
                size_ok = 1'b0;
            end
        endcase
    end

    // Lane placement: shift the data and the mask by the byte offset.
    always_comb begin
        off     = req_addr[1:0];
        lane    = LANE_W'(trunc) << {off, 3'b000};
        mask8   = {4'b0000, mask4} << off;
        crosses = |mask8[7:4];
`ifdef STORE_MISALIGNED_SPLIT_EN
        reject  = !size_ok;
`else
        reject  = !size_ok || crosses;
`endif
        accept  = req_valid && req_ready;
    end

    // Ready is decoded from state so it tracks the FSM with no extra delay.
    always_comb begin
        req_ready = (state == IDLE);
    end

    // Control FSM with registered beat fields and done/err pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'b0000;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
            need_hi   <= 1'b0;
            hi_wdata  <= 32'h0;
            hi_be     <= 4'b0000;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (reject) begin
                            // Rejected: pulse err, no beat, stay idle.
                            err <= 1'b1;
                        end else begin
                            state     <= BEAT0;
                            mem_valid <= 1'b1;
                            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata <= lane[31:0];
                            mem_be    <= mask8[3:0];
`ifdef STORE_MISALIGNED_SPLIT_EN
                            need_hi   <= crosses;
                            hi_wdata  <= lane[63:32];
                            hi_be     <= mask8[7:4];
`endif
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
`ifdef STORE_MISALIGNED_SPLIT_EN
                        if (need_hi) begin
                            // Next word; the adder wraps modulo 2^ADDR_WIDTH.
                            state     <= BEAT1;
                            mem_addr  <= mem_addr + ADDR_WIDTH'(4);
                            mem_wdata <= hi_wdata;
                            mem_be    <= hi_be;
                        end else begin
                            state     <= IDLE;
                            mem_valid <= 1'b0;
                            mem_addr  <= '0;
                            mem_wdata <= 32'h0;
                            mem_be    <= 4'b0000;
                            done      <= 1'b1;
                        end
`else
                        state     <= IDLE;
                        mem_valid <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= 32'h0;
                        mem_be    <= 4'b0000;
                        done      <= 1'b1;
`endif
                    end
                end
`ifdef STORE_MISALIGNED_SPLIT_EN
                BEAT1: begin
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_valid <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= 32'h0;
                        mem_be    <= 4'b0000;
                        need_hi   <= 1'b0;
                        done      <= 1'b1;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_data_align.sv
// Directed bench for store_data_align with hand-computed expected beats.
// Works in both builds; split-specific cases follow STORE_MISALIGNED_SPLIT_EN.
module tb_store_data_align;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    store_data_align #(.ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge; returns just after acceptance.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        chk({tag, ".valid"}, 64'(mem_valid), 64'd1);
        chk({tag, ".addr"},  64'(mem_addr),  64'(a));
        chk({tag, ".wdata"}, 64'(mem_wdata), 64'(d));
        chk({tag, ".be"},    64'(mem_be),    64'(be));
    endtask

    task automatic chk_done(input string tag);
        chk({tag, ".done"},  64'(done),      64'd1);
        chk({tag, ".valid0"}, 64'(mem_valid), 64'd0);
        chk({tag, ".ready"}, 64'(req_ready), 64'd1);
        step();
        chk({tag, ".done0"}, 64'(done),      64'd0);
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst.ready", 64'(req_ready), 64'd1);
        chk("rst.valid", 64'(mem_valid), 64'd0);
        chk("rst.addr",  64'(mem_addr),  64'd0);
        chk("rst.wdata", 64'(mem_wdata), 64'd0);
        chk("rst.be",    64'(mem_be),    64'd0);
        chk("rst.done",  64'(done),      64'd0);
        chk("rst.err",   64'(err),       64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Byte at offset 3
        issue(32'h0000_1003, 32'hAABB_CCDD, 2'b00);
        chk_beat("byte", 32'h0000_1000, 32'hDD00_0000, 4'b1000);
        chk("byte.busy", 64'(req_ready), 64'd0);
        step();
        chk_done("byte");

        // Half at offset 2
        issue(32'h0000_2002, 32'h1234_5678, 2'b01);
        chk_beat("half", 32'h0000_2000, 32'h5678_0000, 4'b1100);
        step();
        chk_done("half");

        // Misaligned word at offset 1
        issue(32'h0000_3001, 32'h1122_3344, 2'b10);
`ifdef STORE_MISALIGNED_SPLIT_EN
        chk_beat("mis.b0", 32'h0000_3000, 32'h2233_4400, 4'b1110);
        chk("mis.nodone", 64'(done), 64'd0);
        step();
        chk_beat("mis.b1", 32'h0000_3004, 32'h0000_0011, 4'b0001);
        step();
        chk_done("mis");
`else
        chk("mis.err",   64'(err),       64'd1);
        chk("mis.valid", 64'(mem_valid), 64'd0);
        chk("mis.ready", 64'(req_ready), 64'd1);
        step();
        chk("mis.err0",  64'(err),       64'd0);
        chk("mis.valid1", 64'(mem_valid), 64'd0);
        chk("mis.done",  64'(done),      64'd0);
        // Half at offset 3 also crosses the word boundary
        issue(32'h0000_5003, 32'h0000_BEEF, 2'b01);
        chk("h3.err",   64'(err),       64'd1);
        chk("h3.valid", 64'(mem_valid), 64'd0);
        step();
`endif

`ifdef STORE_MISALIGNED_SPLIT_EN
        // Wrap-around of the second beat address
        issue(32'hFFFF_FFFE, 32'hCAFE_BABE, 2'b10);
        chk_beat("wrap.b0", 32'hFFFF_FFFC, 32'hBABE_0000, 4'b1100);
        step();
        chk_beat("wrap.b1", 32'h0000_0000, 32'h0000_CAFE, 4'b0011);
        step();
        chk_done("wrap");
`endif

        // Backpressure on beat 0 with a competing request pulsed
        mem_ready = 1'b0;
        issue(32'h0000_4000, 32'hDEAD_BEEF, 2'b10);
        for (int i = 0; i < 3; i++) begin
            req_addr  = 32'h0000_6000;
            req_data  = 32'h0101_0101;
            req_size  = 2'b00;
            req_valid = (i == 1);
            chk_beat("bp.hold", 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111);
            chk("bp.ready", 64'(req_ready), 64'd0);
            chk("bp.done",  64'(done),      64'd0);
            step();
        end
        req_valid = 1'b0;
        chk_beat("bp.last", 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111);
        mem_ready = 1'b1;
        step();
        chk_done("bp");
        chk("bp.nosecond", 64'(mem_valid), 64'd0);
        step();
        chk("bp.nodone2", 64'(done), 64'd0);

        // Reset during an in-flight store
`ifdef STORE_MISALIGNED_SPLIT_EN
        issue(32'h0000_3001, 32'h1122_3344, 2'b10);
        step();
        chk_beat("rmid.b1", 32'h0000_3004, 32'h0000_0011, 4'b0001);
`else
        mem_ready = 1'b0;
        issue(32'h0000_7000, 32'h5555_AAAA, 2'b10);
        chk_beat("rmid.b0", 32'h0000_7000, 32'h5555_AAAA, 4'b1111);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid.valid", 64'(mem_valid), 64'd0);
        chk("rmid.ready", 64'(req_ready), 64'd1);
        chk("rmid.done",  64'(done),      64'd0);
        mem_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk("rmid.done2",  64'(done),      64'd0);
        chk("rmid.err",    64'(err),       64'd0);
        chk("rmid.valid2", 64'(mem_valid), 64'd0);

        // Illegal size
        issue(32'h0000_0000, 32'h1234_5678, 2'b11);
        chk("ill.err",   64'(err),       64'd1);
        chk("ill.valid", 64'(mem_valid), 64'd0);
        chk("ill.ready", 64'(req_ready), 64'd1);
        step();
        chk("ill.err0",  64'(err),       64'd0);
        chk("ill.valid1", 64'(mem_valid), 64'd0);
        chk("ill.done",  64'(done),      64'd0);

        // Back-to-back aligned store after an error
        issue(32'h0000_8001, 32'h0000_00A5, 2'b00);
        chk_beat("b2b", 32'h0000_8000, 32'h0000_A500, 4'b0010);
        step();
        chk_done("b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
